// File: rtl/dma_read_master_if.sv
// AXI4 read-channel bundle (AR + R) between the DMA read master and the fabric.
// Ports: AR address/control plus ARVALID/ARREADY; R data/resp/last plus RVALID/RREADY.
// modport master drives AR and RREADY; modport slave drives ARREADY and R.
interface dma_read_master_if #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ID_WIDTH-1:0]   M_AXI_ARID;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [7:0]            M_AXI_ARLEN;
  logic [2:0]            M_AXI_ARSIZE;
  logic [1:0]            M_AXI_ARBURST;
  logic                  M_AXI_ARLOCK;
  logic [3:0]            M_AXI_ARCACHE;
  logic [2:0]            M_AXI_ARPROT;
  logic [3:0]            M_AXI_ARQOS;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [ID_WIDTH-1:0]   M_AXI_RID;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RLAST;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
           M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID,
           M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
           M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
           M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID,
           M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
           M_AXI_RVALID
  );
endinterface

// File: rtl/dma_read_master.sv
// AXI4 read master: fetches i_total_len bytes from i_src_addr as INCR bursts
// that never cross a 4 KB boundary and streams each accepted beat into a FIFO.
// Ports:
//   M_AXI_ACLK / M_AXI_ARESET      clock, async active-high reset
//   i_start, i_src_addr, i_total_len  transfer request (start sampled in IDLE)
//   i_fifo_full / o_fifo_wr_en / o_fifo_wr_data  FIFO write side
//   o_busy, o_read_done, ERROR     status
//   m_axi                          AR + R channels (master modport)
module dma_read_master #(
  parameter int unsigned C_M_AXI_BURST_LEN  = 16,
  parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          i_start,
  input  logic [31:0]                   i_src_addr,
  input  logic [31:0]                   i_total_len,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_fifo_wr_data,
  output logic                          o_busy,
  output logic                          o_read_done,
  output logic                          ERROR,
  dma_read_master_if.master             m_axi
);

  localparam int unsigned REM_W = 30;
  localparam int unsigned BB_W  = 9;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CALC = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [31:0]      cur_addr_q, cur_addr_d;
  logic [REM_W-1:0] rem_beats_q, rem_beats_d;
  logic [BB_W-1:0]  burst_beats_q, burst_beats_d;
  logic [BB_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [7:0]       arlen_q, arlen_d;
  logic             arvalid_q, arvalid_d;
  logic             error_q, error_d;

  logic [10:0]      bound_beats_c;
  logic [REM_W-1:0] cap_c;
  logic [BB_W-1:0]  calc_beats_c;
  logic             last_beat_c;
  logic             rready_c;
  logic             beat_acc_c;
  logic [REM_W-1:0] rem_after_c;
  logic [31:0]      addr_after_c;

  // Beats left before the next 4 KB page (1..1024); cur_addr is word aligned.
  assign bound_beats_c = 11'd1024 - {1'b0, cur_addr_q[11:2]};

  // Burst size = min(max burst, remaining beats, beats to page boundary).
  always_comb begin
    cap_c = REM_W'(C_M_AXI_BURST_LEN);
    if (rem_beats_q < cap_c) cap_c = rem_beats_q;
    if (REM_W'(bound_beats_c) < cap_c) cap_c = REM_W'(bound_beats_c);
    calc_beats_c = BB_W'(cap_c);
  end

  assign last_beat_c  = (beat_cnt_q == (burst_beats_q - 9'd1));
  assign rready_c     = (state_q == ST_DATA) && !i_fifo_full;
  assign beat_acc_c   = rready_c && m_axi.M_AXI_RVALID;
  assign rem_after_c  = rem_beats_q - REM_W'(burst_beats_q);
  assign addr_after_c = cur_addr_q + {21'd0, burst_beats_q, 2'b00};

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    rem_beats_d   = rem_beats_q;
    burst_beats_d = burst_beats_q;
    beat_cnt_d    = beat_cnt_q;
    araddr_d      = araddr_q;
    arlen_d       = arlen_q;
    arvalid_d     = arvalid_q;
    error_d       = error_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          cur_addr_d  = {i_src_addr[31:2], 2'b00};
          rem_beats_d = i_total_len[31:2];
          error_d     = 1'b0;
          state_d     = (i_total_len[31:2] == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        burst_beats_d = calc_beats_c;
        araddr_d      = cur_addr_q;
        arlen_d       = 8'(calc_beats_c - 9'd1);
        beat_cnt_d    = '0;
        arvalid_d     = 1'b1;
        state_d       = ST_ADDR;
      end
      ST_ADDR: begin
        if (m_axi.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_acc_c) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (m_axi.M_AXI_RRESP != 2'b00) error_d = 1'b1;
          // RLAST is only checked; our own beat counter closes the burst.
          if (m_axi.M_AXI_RLAST != last_beat_c) error_d = 1'b1;
          if (last_beat_c) begin
            cur_addr_d  = addr_after_c;
            rem_beats_d = rem_after_c;
            state_d     = (rem_after_c != '0) ? ST_CALC : ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q       <= ST_IDLE;
      cur_addr_q    <= '0;
      rem_beats_q   <= '0;
      burst_beats_q <= '0;
      beat_cnt_q    <= '0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      arvalid_q     <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      rem_beats_q   <= rem_beats_d;
      burst_beats_q <= burst_beats_d;
      beat_cnt_q    <= beat_cnt_d;
      araddr_q      <= araddr_d;
      arlen_q       <= arlen_d;
      arvalid_q     <= arvalid_d;
      error_q       <= error_d;
    end
  end

  assign m_axi.M_AXI_ARID    = '0;
  assign m_axi.M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'(araddr_q);
  assign m_axi.M_AXI_ARLEN   = arlen_q;
  assign m_axi.M_AXI_ARSIZE  = 3'b010;
  assign m_axi.M_AXI_ARBURST = 2'b01;
  assign m_axi.M_AXI_ARLOCK  = 1'b0;
  assign m_axi.M_AXI_ARCACHE = 4'b0010;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARQOS   = 4'b0000;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_c;

  assign o_fifo_wr_en   = beat_acc_c;
  assign o_fifo_wr_data = m_axi.M_AXI_RDATA;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_read_done    = (state_q == ST_DONE);
  assign ERROR          = error_q;

  // Inputs that are intentionally ignored.
  logic unused_c;
  assign unused_c = ^{i_src_addr[1:0], i_total_len[1:0], m_axi.M_AXI_RID};

endmodule
